// File: rtl/swt16_dmem_arbiter_if.sv
// swt16_dmem_arbiter_if: core, debug and dmem signals of the data-memory arbiter
interface swt16_dmem_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          core_rd_en;
    logic          core_wr_en;
    logic [AW-1:0] core_rd_addr;
    logic [AW-1:0] core_wr_addr;
    logic [DW-1:0] core_wr_word;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wr_word;
    logic [DW-1:0] mem_rd_word;
    logic [AW-1:0] mem_rd_addr;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_word;
    logic          mem_write_en;
    logic          dbg_busy;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rd_word;
    logic          core_stall;

    modport slave (
        input  core_rd_en, core_wr_en, core_rd_addr, core_wr_addr, core_wr_word,
        input  dbg_req, dbg_we, dbg_addr, dbg_wr_word, mem_rd_word,
        output mem_rd_addr, mem_wr_addr, mem_wr_word, mem_write_en,
        output dbg_busy, dbg_ack, dbg_rd_word, core_stall
    );

    modport master (
        output core_rd_en, core_wr_en, core_rd_addr, core_wr_addr, core_wr_word,
        output dbg_req, dbg_we, dbg_addr, dbg_wr_word, mem_rd_word,
        input  mem_rd_addr, mem_wr_addr, mem_wr_word, mem_write_en,
        input  dbg_busy, dbg_ack, dbg_rd_word, core_stall
    );
endinterface

// File: rtl/swt16_dmem_arbiter.sv
// swt16_dmem_arbiter: core-priority dmem sharing with a debug port; SWT16_DMEM_ARB_STARVE_GUARD_EN adds a forced debug slot
module swt16_dmem_arbiter #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DMEM_WORD_WIDTH = 16
`ifdef SWT16_DMEM_ARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = 8
`endif
) (
    input logic clock,
    input logic reset,
    swt16_dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PEND, RDATA} state_t;

    state_t                     state, next;
    logic                       cap_we;
    logic [DMEM_ADDR_WIDTH-1:0] cap_addr;
    logic [DMEM_WORD_WIDTH-1:0] cap_word;
    logic [DMEM_WORD_WIDTH-1:0] rd_word;
    logic                       ack;
    logic                       core_idle;
    logic                       force_slot;
    logic                       issue;

    assign core_idle = !bus.core_rd_en && !bus.core_wr_en;
    assign issue     = (state == PEND) && (core_idle || force_slot);

`ifdef SWT16_DMEM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] cnt;

    // only blocked PEND cycles advance the counter; it holds once saturated
    always_ff @(posedge clock) begin
        if (reset)
            cnt <= '0;
        else if (issue)
            cnt <= '0;
        else if (state == PEND && !core_idle && cnt != CW'(STARVE_LIMIT))
            cnt <= cnt + 1'b1;
    end

    assign force_slot = (state == PEND) && (cnt == CW'(STARVE_LIMIT));
`else
    assign force_slot = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            ack     <= 1'b0;
            rd_word <= '0;
        end else begin
            state <= next;
            ack   <= (issue && cap_we) || (state == RDATA);
            if (state == RDATA)
                rd_word <= bus.mem_rd_word;
            if (state == IDLE && bus.dbg_req) begin
                cap_we   <= bus.dbg_we;
                cap_addr <= bus.dbg_addr;
                cap_word <= bus.dbg_wr_word;
            end
        end
    end

    always_comb begin
        next = state == IDLE ? (bus.dbg_req ? PEND : IDLE) :
               state == PEND ? (issue ? (cap_we ? IDLE : RDATA) : PEND) : IDLE;
    end

    assign bus.mem_rd_addr  = issue ? cap_addr : bus.core_rd_addr;
    assign bus.mem_wr_addr  = issue ? cap_addr : bus.core_wr_addr;
    assign bus.mem_wr_word  = issue ? cap_word : bus.core_wr_word;
    assign bus.mem_write_en = reset ? 1'b0 : issue ? cap_we : bus.core_wr_en;
    assign bus.dbg_busy     = state != IDLE;
    assign bus.dbg_ack      = ack;
    assign bus.dbg_rd_word  = rd_word;
    assign bus.core_stall   = force_slot;
endmodule
